// File: rtl/life_grid_mem_arbiter.sv
// Shares the single-port cell-grid RAM between loader, generation engine and display scan.
// Bursty grants with a dead TURN cycle between owners; read data returns one cycle later, owner-tagged.
module life_grid_mem_arbiter #(
  parameter int ADDR_W    = 9,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 15,
  parameter int BURST_W   = 4
) (
  input  logic              clka,
  input  logic              reset,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_gnt,
  output logic              ld_rvalid,
  input  logic              gen_req,
  input  logic              gen_we,
  input  logic [ADDR_W-1:0] gen_addr,
  input  logic [DATA_W-1:0] gen_wdata,
  output logic              gen_gnt,
  output logic              gen_rvalid,
  input  logic              dsp_req,
  input  logic [ADDR_W-1:0] dsp_addr,
  output logic              dsp_gnt,
  output logic              dsp_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        owner,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, OWN, TURN} state_t;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_LD   = 2'd1;
  localparam logic [1:0] OWN_GEN  = 2'd2;
  localparam logic [1:0] OWN_DSP  = 2'd3;

  state_t             state_reg, state_next;
  logic [1:0]         owner_reg, owner_next;
  logic [BURST_W-1:0] burst_reg, burst_next;
  logic               rr_dsp_last_reg, rr_dsp_last_next;
  logic [1:0]         tag_reg, tag_next;

  logic               own_req;
  logic               own_we;
  logic [ADDR_W-1:0]  own_addr;
  logic [DATA_W-1:0]  own_wdata;
  logic               others_pending;
  logic               beat;
  logic [BURST_W-1:0] burst_inc;
  logic [1:0]         pick;
  logic [3:1]         gnt_vec;
  logic [3:1]         rvalid_vec;

  always_comb begin
    own_req        = 1'b0;
    own_we         = 1'b0;
    own_addr       = '0;
    own_wdata      = '0;
    others_pending = 1'b0;
    case (owner_reg)
      OWN_LD: begin
        own_req        = ld_req;
        own_we         = ld_we;
        own_addr       = ld_addr;
        own_wdata      = ld_wdata;
        others_pending = gen_req | dsp_req;
      end
      OWN_GEN: begin
        own_req        = gen_req;
        own_we         = gen_we;
        own_addr       = gen_addr;
        own_wdata      = gen_wdata;
        others_pending = ld_req | dsp_req;
      end
      OWN_DSP: begin
        own_req        = dsp_req;
        own_addr       = dsp_addr;
        others_pending = ld_req | gen_req;
      end
      default: ;
    endcase
  end

  assign beat      = (state_reg == OWN) && own_req;
  assign burst_inc = burst_reg + BURST_W'(1);

  // ld always wins; gen/dsp alternate on a tie, starting from whichever did not go last
  always_comb begin
    pick = OWN_NONE;
    if (ld_req)
      pick = OWN_LD;
    else if (gen_req && dsp_req)
      pick = rr_dsp_last_reg ? OWN_GEN : OWN_DSP;
    else if (gen_req)
      pick = OWN_GEN;
    else if (dsp_req)
      pick = OWN_DSP;
  end

  always_comb begin
    state_next       = state_reg;
    owner_next       = owner_reg;
    burst_next       = burst_reg;
    rr_dsp_last_next = rr_dsp_last_reg;
    case (state_reg)
      OWN: begin
        if (!own_req) begin
          state_next = TURN;
          owner_next = OWN_NONE;
        end else if (burst_inc == BURST_W'(MAX_BURST)) begin
          burst_next = '0;
          if (others_pending) begin
            state_next = TURN;
            owner_next = OWN_NONE;
          end
        end else begin
          burst_next = burst_inc;
        end
      end
      default: begin
        if (pick != OWN_NONE) begin
          state_next = OWN;
          owner_next = pick;
          burst_next = '0;
          if (pick == OWN_GEN) rr_dsp_last_next = 1'b0;
          if (pick == OWN_DSP) rr_dsp_last_next = 1'b1;
        end else begin
          state_next = IDLE;
          owner_next = OWN_NONE;
        end
      end
    endcase
  end

  assign mem_en    = beat;
  assign mem_we    = beat && own_we && (owner_reg != OWN_DSP);
  assign mem_addr  = beat ? own_addr : '0;
  assign mem_wdata = beat ? own_wdata : '0;
  assign tag_next  = (beat && !mem_we) ? owner_reg : OWN_NONE;

  always_ff @(posedge clka or negedge reset) begin
    if (!reset) begin
      state_reg       <= IDLE;
      owner_reg       <= OWN_NONE;
      burst_reg       <= '0;
      rr_dsp_last_reg <= 1'b1;
      tag_reg         <= OWN_NONE;
    end else begin
      state_reg       <= state_next;
      owner_reg       <= owner_next;
      burst_reg       <= burst_next;
      rr_dsp_last_reg <= rr_dsp_last_next;
      tag_reg         <= tag_next;
    end
  end

  // owner_reg is OWN_NONE outside OWN, so per-requester decodes need no state term
  generate
    for (genvar gi = 1; gi <= 3; gi++) begin : g_req
      assign gnt_vec[gi]    = (owner_reg == 2'(gi));
      assign rvalid_vec[gi] = (tag_reg == 2'(gi));
    end
  endgenerate

  assign ld_gnt     = gnt_vec[1];
  assign gen_gnt    = gnt_vec[2];
  assign dsp_gnt    = gnt_vec[3];
  assign ld_rvalid  = rvalid_vec[1];
  assign gen_rvalid = rvalid_vec[2];
  assign dsp_rvalid = rvalid_vec[3];
  assign rdata      = (tag_reg != OWN_NONE) ? mem_rdata : '0;
  assign owner      = owner_reg;
  assign busy       = (state_reg == OWN);

endmodule

// File: tb/tb_life_grid_mem_arbiter.sv
// Randomized and directed checks of life_grid_mem_arbiter against a cycle-level reference model.
// Owner codes in the model: 0 none, 1 ld, 2 gen, 3 dsp.
module tb_life_grid_mem_arbiter;

  logic       clka = 1'b0;
  logic       reset = 1'b0;
  logic       ld_req = 0, ld_we = 0, gen_req = 0, gen_we = 0, dsp_req = 0;
  logic [8:0] ld_addr = 0, gen_addr = 0, dsp_addr = 0;
  logic [7:0] ld_wdata = 0, gen_wdata = 0;
  logic       ld_gnt, ld_rvalid, gen_gnt, gen_rvalid, dsp_gnt, dsp_rvalid;
  logic [7:0] rdata, mem_wdata;
  logic [7:0] mem_rdata = 8'h00;
  logic       mem_en, mem_we, busy;
  logic [8:0] mem_addr;
  logic [1:0] owner;

  int checks_cnt = 0;
  int errors_cnt = 0;
  int cyc = 0;

  logic [7:0] ram [512];
  logic [7:0] shadow [512];

  // reference model state
  int         m_mode;   // 0 idle, 1 owned, 2 turn
  int         m_owner;
  int         m_beats;
  int         m_rr;
  int         m_tag;
  logic [7:0] m_rdata;
  bit         m_beat_last;

  always #5 clka = ~clka;

  always @(posedge clka) begin
    if (mem_en) begin
      mem_rdata <= ram[mem_addr];
      if (mem_we) ram[mem_addr] <= mem_wdata;
    end
  end

  life_grid_mem_arbiter dut (
    .clka(clka), .reset(reset),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid),
    .gen_req(gen_req), .gen_we(gen_we), .gen_addr(gen_addr), .gen_wdata(gen_wdata),
    .gen_gnt(gen_gnt), .gen_rvalid(gen_rvalid),
    .dsp_req(dsp_req), .dsp_addr(dsp_addr), .dsp_gnt(dsp_gnt), .dsp_rvalid(dsp_rvalid),
    .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .owner(owner), .busy(busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      errors_cnt++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic bit req_of(int who);
    case (who)
      1: return ld_req;
      2: return gen_req;
      3: return dsp_req;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit we_of(int who);
    case (who)
      1: return ld_we;
      2: return gen_we;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [8:0] addr_of(int who);
    case (who)
      1: return ld_addr;
      2: return gen_addr;
      3: return dsp_addr;
      default: return 9'd0;
    endcase
  endfunction

  function automatic logic [7:0] wdata_of(int who);
    case (who)
      1: return ld_wdata;
      2: return gen_wdata;
      default: return 8'd0;
    endcase
  endfunction

  function automatic int cur_owner();
    return (m_mode == 1) ? m_owner : 0;
  endfunction

  function automatic bit cur_beat();
    return (m_mode == 1) && req_of(m_owner);
  endfunction

  task automatic model_reset();
    m_mode  = 0;
    m_owner = 0;
    m_beats = 0;
    m_rr    = 3;
    m_tag   = 0;
    m_rdata = 8'h00;
    m_beat_last = 1'b0;
  endtask

  task automatic compare_outputs();
    int own;
    bit b;
    bit w;
    own = cur_owner();
    b   = cur_beat();
    w   = b && we_of(own);
    check_eq("gnt", {29'd0, dsp_gnt, gen_gnt, ld_gnt},
             {29'd0, own == 3, own == 2, own == 1});
    check_eq("owner", {30'd0, owner}, own);
    check_eq("busy", {31'd0, busy}, {31'd0, m_mode == 1});
    check_eq("mem_en", {31'd0, mem_en}, {31'd0, b});
    check_eq("mem_we", {31'd0, mem_we}, {31'd0, w});
    check_eq("mem_addr", {23'd0, mem_addr}, b ? {23'd0, addr_of(own)} : 32'd0);
    check_eq("mem_wdata", {24'd0, mem_wdata}, b ? {24'd0, wdata_of(own)} : 32'd0);
    check_eq("rvalid", {29'd0, dsp_rvalid, gen_rvalid, ld_rvalid},
             {29'd0, m_tag == 3, m_tag == 2, m_tag == 1});
    check_eq("rdata", {24'd0, rdata}, (m_tag != 0) ? {24'd0, m_rdata} : 32'd0);
  endtask

  // One clock cycle: inputs already applied at the falling edge.
  task automatic step();
    int own;
    bit b;
    bit w;
    int pending;
    int pick;
    #1;
    compare_outputs();
    own = cur_owner();
    b   = cur_beat();
    w   = b && we_of(own);
    m_beat_last = b;
    m_tag = (b && !w) ? own : 0;
    if (b && !w) m_rdata = shadow[addr_of(own)];
    if (w) shadow[addr_of(own)] = wdata_of(own);
    if (m_mode == 1) begin
      pending = int'(ld_req) + int'(gen_req) + int'(dsp_req) - int'(req_of(m_owner));
      if (!req_of(m_owner)) begin
        m_mode = 2;
      end else begin
        m_beats++;
        if (m_beats == 15) begin
          if (pending > 0) m_mode = 2;
          else m_beats = 0;
        end
      end
    end else begin
      if (ld_req) pick = 1;
      else if (gen_req && dsp_req) pick = (m_rr == 3) ? 2 : 3;
      else if (gen_req) pick = 2;
      else if (dsp_req) pick = 3;
      else pick = 0;
      if (pick != 0) begin
        $display("[%0d] grant to requester %0d", cyc, pick);
        m_mode  = 1;
        m_owner = pick;
        m_beats = 0;
        if (pick != 1) m_rr = pick;
      end else begin
        m_mode = 0;
      end
    end
    @(posedge clka);
    cyc++;
    @(negedge clka);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    model_reset();
    compare_outputs();
    @(posedge clka);
    #1;
    compare_outputs();
    @(negedge clka);
    reset = 1'b1;
  endtask

  task automatic clear_reqs();
    ld_req = 0; gen_req = 0; dsp_req = 0;
    ld_we = 0; gen_we = 0;
  endtask

  initial begin
    logic [8:0] la [4];
    logic [7:0] ldat [4];
    logic       lwe [4];
    int n;
    int idx;
    int guard;

    la   = '{9'h005, 9'h006, 9'h007, 9'h006};
    ldat = '{8'hA1, 8'hA2, 8'hA3, 8'h00};
    lwe  = '{1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 512; i++) begin
      ram[i]    = 8'($urandom);
      shadow[i] = ram[i];
    end
    model_reset();
    @(negedge clka);
    do_reset();

    // loader: three writes then a read back
    ld_req = 1;
    idx = 0;
    guard = 0;
    while (idx < 4 && guard < 20) begin
      ld_we = lwe[idx]; ld_addr = la[idx]; ld_wdata = ldat[idx];
      step();
      if (m_beat_last) idx++;
      guard++;
    end
    check_eq("ld_seq_done", idx, 4);
    check_eq("ld_rvalid_a2", {31'd0, ld_rvalid}, 1);
    check_eq("ld_rdata_a2", {24'd0, rdata}, 32'hA2);
    clear_reqs();
    step();
    step();

    // gen and dsp both held from reset: 15-beat bursts alternating through TURN
    do_reset();
    gen_req = 1; dsp_req = 1; gen_addr = 9'h010; dsp_addr = 9'h020;
    step();
    n = 0;
    while (gen_gnt === 1'b1 && n < 40) begin step(); n++; end
    check_eq("gen_burst_len", n, 15);
    check_eq("turn1_no_gnt", {30'd0, gen_gnt, dsp_gnt}, 0);
    step();
    n = 0;
    while (dsp_gnt === 1'b1 && n < 40) begin step(); n++; end
    check_eq("dsp_burst_len", n, 15);
    check_eq("turn2_no_gnt", {30'd0, gen_gnt, dsp_gnt}, 0);
    step();
    check_eq("rr_back_to_gen", {31'd0, gen_gnt}, 1);
    clear_reqs();
    step();

    // ld arrives mid-burst: gen finishes, ld takes the next TURN ahead of dsp
    do_reset();
    gen_req = 1; dsp_req = 1;
    step();
    n = 0;
    while (gen_gnt === 1'b1 && n < 40) begin
      step();
      n++;
      if (n == 4) ld_req = 1;
    end
    check_eq("gen_burst_ld_wait", n, 15);
    check_eq("turn_before_ld", {29'd0, ld_gnt, gen_gnt, dsp_gnt}, 0);
    step();
    check_eq("ld_wins_turn", {29'd0, ld_gnt, gen_gnt, dsp_gnt}, 32'd4);
    clear_reqs();
    step();

    // gen alone keeps ownership across burst wraps
    do_reset();
    gen_req = 1;
    n = 0;
    for (int i = 0; i < 45; i++) begin
      gen_we = 1'($urandom); gen_addr = 9'($urandom); gen_wdata = 8'($urandom);
      step();
      if (gen_gnt === 1'b1) n++;
    end
    check_eq("gen_alone_hold", n, 45);
    clear_reqs();
    step();

    // gen write then dsp read of the same cell across the TURN
    do_reset();
    gen_req = 1; gen_we = 1; gen_addr = 9'h1FF; gen_wdata = 8'h3C;
    guard = 0;
    do begin step(); guard++; end while (!m_beat_last && guard < 10);
    clear_reqs();
    dsp_req = 1; dsp_addr = 9'h1FF;
    guard = 0;
    do begin step(); guard++; end while (!m_beat_last && guard < 10);
    check_eq("dsp_rvalid_1ff", {31'd0, dsp_rvalid}, 1);
    check_eq("dsp_rdata_1ff", {24'd0, rdata}, 32'h3C);
    clear_reqs();
    step();

    // reset in the middle of a gen read burst, then gen re-granted
    do_reset();
    gen_req = 1; gen_we = 0; gen_addr = 9'h033;
    for (int i = 0; i < 5; i++) step();
    do_reset();
    check_eq("post_reset_no_rvalid", {31'd0, gen_rvalid}, 0);
    step();
    check_eq("gen_regrant", {31'd0, gen_gnt}, 1);

    // random traffic with sticky requests and occasional resets
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(31) == 0) ld_req = ~ld_req;
      if ($urandom_range(15) == 0) gen_req = ~gen_req;
      if ($urandom_range(15) == 0) dsp_req = ~dsp_req;
      ld_we = 1'($urandom); gen_we = 1'($urandom);
      ld_addr = 9'($urandom_range(15)); gen_addr = 9'($urandom_range(15));
      dsp_addr = 9'($urandom_range(15));
      ld_wdata = 8'($urandom); gen_wdata = 8'($urandom);
      if ($urandom_range(399) == 0) do_reset();
      else step();
    end

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
